controlunit_mc: RTL and testbench

CONTROLUNIT_MC -- requirements
Module: controlunit_mc

---
 rtl/controlunit_pkg.sv | 49 ++++
 rtl/controlunit_decode.sv | 78 +++++++
 rtl/controlunit_mc.sv | 171 +++++++++++++++++
 tb/tb_controlunit_mc.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlunit_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states,
// decoded instruction classes, opcodes, fixed ALU codes and immediate selects.
package controlunit_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  // Instruction class produced by the decoder from the latched opcode.
  typedef enum logic [3:0] {
    CLS_ALU  = 4'd0,
    CLS_ALUI = 4'd1,
    CLS_LD   = 4'd2,
    CLS_ST   = 4'd3,
    CLS_BEQ  = 4'd4,
    CLS_BNE  = 4'd5,
    CLS_JMP  = 4'd6,
    CLS_HALT = 4'd7,
    CLS_ILL  = 4'd8
  } cls_e;

  // Opcodes. OP_HALT is -1 so that a size cast to any opcode width gives all ones.
  localparam int OP_ALU  = 0;
  localparam int OP_ALUI = 1;
  localparam int OP_LD   = 2;
  localparam int OP_ST   = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_BNE  = 5;
  localparam int OP_JMP  = 6;
  localparam int OP_HALT = -1;

  // ALU operations forced by the controller for address and compare work.
  localparam int ALU_OP_ADD = 9;
  localparam int ALU_OP_SUB = 6;

  // Immediate format selects.
  localparam int IMM_R = 0;
  localparam int IMM_I = 1;
  localparam int IMM_S = 2;
  localparam int IMM_B = 3;

endpackage

// File: rtl/controlunit_decode.sv
// Combinational opcode decode: instruction class, immediate select and the
// ALU controls that the FSM presents during EXEC.
module controlunit_decode
  import controlunit_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int ALU_OP_W  = 4,
  parameter int IMM_SEL_W = 2
) (
  input  logic [OPC_W-1:0]     i_op,
  input  logic [ALU_OP_W-1:0]  i_funct,
  input  logic                 i_m_bit,
  input  logic                 i_c_bit,
  output cls_e                 o_cls,
  output logic [IMM_SEL_W-1:0] o_imm_sel,
  output logic [ALU_OP_W-1:0]  o_alu_op,
  output logic                 o_alu_m,
  output logic                 o_c0
);

  // Map the opcode to a class plus its datapath controls; unknown opcodes are illegal.
  always_comb begin
    o_cls     = CLS_ILL;
    o_imm_sel = '0;
    o_alu_op  = '0;
    o_alu_m   = 1'b0;
    o_c0      = 1'b0;
    case (i_op)
      OPC_W'(OP_ALU): begin
        o_cls     = CLS_ALU;
        o_imm_sel = IMM_SEL_W'(IMM_R);
        o_alu_op  = i_funct;
        o_alu_m   = i_m_bit;
        o_c0      = i_c_bit;
      end
      OPC_W'(OP_ALUI): begin
        o_cls     = CLS_ALUI;
        o_imm_sel = IMM_SEL_W'(IMM_I);
        o_alu_op  = i_funct;
        o_alu_m   = i_m_bit;
        o_c0      = i_c_bit;
      end
      OPC_W'(OP_LD): begin
        o_cls     = CLS_LD;
        o_imm_sel = IMM_SEL_W'(IMM_I);
        o_alu_op  = ALU_OP_W'(ALU_OP_ADD);
      end
      OPC_W'(OP_ST): begin
        o_cls     = CLS_ST;
        o_imm_sel = IMM_SEL_W'(IMM_S);
        o_alu_op  = ALU_OP_W'(ALU_OP_ADD);
      end
      OPC_W'(OP_BEQ): begin
        o_cls     = CLS_BEQ;
        o_imm_sel = IMM_SEL_W'(IMM_B);
        o_alu_op  = ALU_OP_W'(ALU_OP_SUB);
        o_c0      = 1'b1;
      end
      OPC_W'(OP_BNE): begin
        o_cls     = CLS_BNE;
        o_imm_sel = IMM_SEL_W'(IMM_B);
        o_alu_op  = ALU_OP_W'(ALU_OP_SUB);
        o_c0      = 1'b1;
      end
      OPC_W'(OP_JMP): begin
        o_cls     = CLS_JMP;
        o_imm_sel = IMM_SEL_W'(IMM_B);
      end
      OPC_W'(OP_HALT): begin
        o_cls     = CLS_HALT;
      end
      default: begin
        o_cls     = CLS_ILL;
      end
    endcase
  end

endmodule

// File: rtl/controlunit_mc.sv
// Multi-cycle processor control unit: FETCH/DECODE/EXEC/MEM/WRITEBACK sequencer
// with sticky HALT and ERR terminal states.
//
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle where mem_req=1 and mem_ready=1, and the controller
// leaves FETCH/MEM on that edge. mem_ready is ignored whenever mem_req=0.
// ir_load and the store's pc_en follow mem_ready in that completing cycle so
// the instruction register and PC update on the same edge the access finishes.
module controlunit_mc
  import controlunit_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int ALU_OP_W  = 4,
  parameter int IMM_SEL_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OPC_W-1:0]     op,
  input  logic [ALU_OP_W-1:0]  funct,
  input  logic                 m_bit,
  input  logic                 c_bit,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 C0,
  output logic                 alu_m,
  output logic [ALU_OP_W-1:0]  ALU_op,
  output logic                 RW,
  output logic                 MRW,
  output logic                 WB,
  output logic                 PCsrc,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 halted,
  output logic                 illegal
);

  state_e                r_state;
  state_e                w_next_state;
  logic [OPC_W-1:0]      r_op;
  logic [ALU_OP_W-1:0]   r_funct;
  logic                  r_m_bit;
  logic                  r_c_bit;

  cls_e                  w_cls;
  logic [IMM_SEL_W-1:0]  w_imm_sel;
  logic [ALU_OP_W-1:0]   w_alu_op;
  logic                  w_alu_m;
  logic                  w_c0;

  controlunit_decode #(
    .OPC_W     (OPC_W),
    .ALU_OP_W  (ALU_OP_W),
    .IMM_SEL_W (IMM_SEL_W)
  ) u_decode (
    .i_op      (r_op),
    .i_funct   (r_funct),
    .i_m_bit   (r_m_bit),
    .i_c_bit   (r_c_bit),
    .o_cls     (w_cls),
    .o_imm_sel (w_imm_sel),
    .o_alu_op  (w_alu_op),
    .o_alu_m   (w_alu_m),
    .o_c0      (w_c0)
  );

  // State register and instruction-field latch; reset wins over mem_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_op    <= '0;
      r_funct <= '0;
      r_m_bit <= 1'b0;
      r_c_bit <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH && mem_ready) begin
        r_op    <= op;
        r_funct <= funct;
        r_m_bit <= m_bit;
        r_c_bit <= c_bit;
      end
    end
  end

  // Next-state sequencing by instruction class.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_cls == CLS_HALT)     w_next_state = ST_HALT;
        else if (w_cls == CLS_ILL) w_next_state = ST_ERR;
        else                       w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_ALU, CLS_ALUI: w_next_state = ST_WRITEBACK;
          CLS_LD, CLS_ST:    w_next_state = ST_MEM;
          default:           w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) w_next_state = (w_cls == CLS_LD) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: w_next_state = ST_FETCH;
      ST_HALT:      w_next_state = ST_HALT;
      ST_ERR:       w_next_state = ST_ERR;
      default:      w_next_state = ST_ERR;
    endcase
  end

  // Output decode from state and latched fields; everything is held at 0 while reset is high.
  always_comb begin
    mem_req = 1'b0;
    ir_load = 1'b0;
    pc_en   = 1'b0;
    C0      = 1'b0;
    alu_m   = 1'b0;
    ALU_op  = '0;
    RW      = 1'b0;
    MRW     = 1'b0;
    WB      = 1'b0;
    PCsrc   = 1'b0;
    imm_sel = '0;
    halted  = 1'b0;
    illegal = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
        end
        ST_DECODE: begin
          imm_sel = w_imm_sel;
        end
        ST_EXEC: begin
          imm_sel = w_imm_sel;
          ALU_op  = w_alu_op;
          alu_m   = w_alu_m;
          C0      = w_c0;
          if (w_cls == CLS_BEQ || w_cls == CLS_BNE || w_cls == CLS_JMP) begin
            pc_en = 1'b1;
            PCsrc = (w_cls == CLS_JMP) ||
                    (w_cls == CLS_BEQ && zero) ||
                    (w_cls == CLS_BNE && !zero);
          end
        end
        ST_MEM: begin
          imm_sel = w_imm_sel;
          mem_req = 1'b1;
          MRW     = (w_cls == CLS_ST);
          pc_en   = (w_cls == CLS_ST) && mem_ready;
        end
        ST_WRITEBACK: begin
          imm_sel = w_imm_sel;
          RW      = 1'b1;
          WB      = (w_cls == CLS_LD);
          pc_en   = 1'b1;
        end
        ST_HALT:  halted  = 1'b1;
        ST_ERR:   illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlunit_mc.sv
// Bench for controlunit_mc: a per-instruction model turns each instruction and
// its wait-state pattern into a cycle-by-cycle stream of stimulus and expected
// output vectors; the DUT outputs are sampled on the falling edge.
module tb_controlunit_mc;

  localparam int EXP_W = 17;

  logic       clock;
  logic       reset;
  logic [3:0] op;
  logic [3:0] funct;
  logic       m_bit;
  logic       c_bit;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       ir_load;
  logic       pc_en;
  logic       C0;
  logic       alu_m;
  logic [3:0] ALU_op;
  logic       RW;
  logic       MRW;
  logic       WB;
  logic       PCsrc;
  logic [1:0] imm_sel;
  logic       halted;
  logic       illegal;

  typedef struct {
    logic       rst;
    logic       mr;
    logic       z;
    logic [3:0] op;
    logic [3:0] f;
    logic       m;
    logic       c;
  } stim_t;

  stim_t            stim_q[$];
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  controlunit_mc #(
    .OPC_W     (4),
    .ALU_OP_W  (4),
    .IMM_SEL_W (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .m_bit     (m_bit),
    .c_bit     (c_bit),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .ir_load   (ir_load),
    .pc_en     (pc_en),
    .C0        (C0),
    .alu_m     (alu_m),
    .ALU_op    (ALU_op),
    .RW        (RW),
    .MRW       (MRW),
    .WB        (WB),
    .PCsrc     (PCsrc),
    .imm_sel   (imm_sel),
    .halted    (halted),
    .illegal   (illegal)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  // Expected output vector layout:
  // {mem_req, ir_load, pc_en, C0, alu_m, ALU_op, RW, MRW, WB, PCsrc, imm_sel, halted, illegal}
  function automatic logic [EXP_W-1:0] mk(input logic mreq, input logic irl, input logic pce,
                                          input logic c0, input logic am, input logic [3:0] aop,
                                          input logic rw, input logic mrw, input logic wb,
                                          input logic pcs, input logic [1:0] imm,
                                          input logic hlt, input logic ill);
    return {mreq, irl, pce, c0, am, aop, rw, mrw, wb, pcs, imm, hlt, ill};
  endfunction

  task automatic add_cycle(input logic rst, input logic mr, input logic z, input logic [3:0] o,
                           input logic [3:0] f, input logic m, input logic c,
                           input logic [EXP_W-1:0] e);
    stim_t s;
    s.rst = rst; s.mr = mr; s.z = z; s.op = o; s.f = f; s.m = m; s.c = c;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Cycle whose opcode fields and zero flag must not matter: fill them randomly.
  task automatic add_idle(input logic rst, input logic mr, input logic [EXP_W-1:0] e);
    add_cycle(rst, mr, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), e);
  endtask

  // One instruction from its FETCH to its last cycle. fw/mw are mem_ready=0
  // cycles in the fetch and data accesses; z is the zero flag during EXEC.
  task automatic model_instr(input logic [3:0] o, input logic [3:0] f, input logic m,
                             input logic c, input logic z, input int fw, input int mw);
    bit         is_alu, is_ld, is_st, is_beq, is_bne, is_jmp, is_halt, is_ill, is_br;
    logic [1:0] imm;
    logic [3:0] aop;
    logic       am, c0, pcs;
    is_alu  = (o == 4'd0) || (o == 4'd1);
    is_ld   = (o == 4'd2);
    is_st   = (o == 4'd3);
    is_beq  = (o == 4'd4);
    is_bne  = (o == 4'd5);
    is_jmp  = (o == 4'd6);
    is_halt = (o == 4'hF);
    is_ill  = (o > 4'd6) && !is_halt;
    is_br   = is_beq || is_bne || is_jmp;
    if (o == 4'd0)              imm = 2'd0;
    else if (o == 4'd1 || is_ld) imm = 2'd1;
    else if (is_st)              imm = 2'd2;
    else if (is_br)              imm = 2'd3;
    else                         imm = 2'd0;
    aop = 4'd0; am = 1'b0; c0 = 1'b0;
    if (is_alu) begin
      aop = f; am = m; c0 = c;
    end else if (is_ld || is_st) begin
      aop = 4'd9;
    end else if (is_beq || is_bne) begin
      aop = 4'd6; c0 = 1'b1;
    end
    for (int i = 0; i < fw; i++)
      add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    add_cycle(1'b0, 1'b1, 1'($urandom), o, f, m, c,
              mk(1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    add_idle(1'b0, 1'($urandom), mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, imm, 0, 0));
    if (is_halt || is_ill) return;
    if (is_br) begin
      pcs = is_jmp || (is_beq && z) || (is_bne && !z);
      add_cycle(1'b0, 1'($urandom), z, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                mk(0, 0, 1, c0, am, aop, 0, 0, 0, pcs, imm, 0, 0));
      return;
    end
    add_cycle(1'b0, 1'($urandom), z, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              mk(0, 0, 0, c0, am, aop, 0, 0, 0, 0, imm, 0, 0));
    if (is_ld || is_st) begin
      for (int i = 0; i < mw; i++)
        add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, is_st, 0, 0, imm, 0, 0));
      add_idle(1'b0, 1'b1, mk(1, 0, is_st, 0, 0, 4'd0, 0, is_st, 0, 0, imm, 0, 0));
      if (is_st) return;
    end
    add_idle(1'b0, 1'($urandom), mk(0, 0, 1, 0, 0, 4'd0, 1, 0, is_ld, 0, imm, 0, 0));
  endtask

  // ---------------- driver ----------------
  // Applies queued stimulus one cycle at a time; inputs change #1 after the
  // rising edge and outputs are captured on the falling edge.
  task automatic run_stim();
    stim_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset     = s.rst;
      mem_ready = s.mr;
      zero      = s.z;
      op        = s.op;
      funct     = s.f;
      m_bit     = s.m;
      c_bit     = s.c;
      @(negedge clock);
      obs_q.push_back({mem_req, ir_load, pc_en, C0, alu_m, ALU_op, RW, MRW, WB, PCsrc,
                       imm_sel, halted, illegal});
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EXP_W-1:0] e, o;
    int cyc;
    for (int i = 0; i < 5; i++) add_idle(1'b1, 1'($urandom), '0);
    add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_alu();
    logic [EXP_W-1:0] e, o;
    int cyc;
    model_instr(4'd0, 4'hB, 1'b1, 1'b0, 1'b0, 0, 0);
    model_instr(4'd1, 4'h3, 1'b0, 1'b1, 1'b1, 1, 0);
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL alu cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_ld_st_wait();
    logic [EXP_W-1:0] e, o;
    int cyc;
    model_instr(4'd2, 4'h5, 1'b1, 1'b1, 1'b0, 0, 2);
    model_instr(4'd3, 4'h7, 1'b0, 1'b0, 1'b1, 0, 0);
    model_instr(4'd3, 4'h1, 1'b1, 1'b1, 1'b0, 2, 3);
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ldst cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_branch();
    logic [EXP_W-1:0] e, o;
    int cyc;
    model_instr(4'd4, 4'h0, 1'b1, 1'b0, 1'b1, 0, 0);
    model_instr(4'd4, 4'h0, 1'b1, 1'b0, 1'b0, 0, 0);
    model_instr(4'd5, 4'h2, 1'b0, 1'b0, 1'b1, 0, 0);
    model_instr(4'd5, 4'h2, 1'b0, 1'b0, 1'b0, 0, 0);
    model_instr(4'd6, 4'hF, 1'b1, 1'b1, 1'b0, 1, 0);
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_illegal_halt();
    logic [EXP_W-1:0] e, o;
    int cyc;
    model_instr(4'h9, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++)
      add_idle(1'b0, 1'($urandom), mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 1));
    add_idle(1'b1, 1'b1, '0);
    add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    model_instr(4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++)
      add_idle(1'b0, 1'($urandom), mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 1, 0));
    add_idle(1'b1, 1'b1, '0);
    add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL illhalt cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [EXP_W-1:0] e, o;
    int cyc;
    add_cycle(1'b0, 1'b1, 1'b0, 4'd3, 4'h4, 1'b0, 1'b0,
              mk(1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    add_idle(1'b0, 1'($urandom), mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd2, 0, 0));
    add_idle(1'b0, 1'($urandom), mk(0, 0, 0, 0, 0, 4'd9, 0, 0, 0, 0, 2'd2, 0, 0));
    add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 2'd2, 0, 0));
    add_idle(1'b1, 1'b1, '0);
    add_idle(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0));
    model_instr(4'd0, 4'h6, 1'b0, 1'b1, 1'b0, 0, 0);
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rstmem cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back_random();
    logic [EXP_W-1:0] e, o;
    int cyc;
    for (int i = 0; i < 40; i++)
      model_instr(4'($urandom_range(0, 6)), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    run_stim();
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%b exp=%b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    op        = '0;
    funct     = '0;
    m_bit     = 1'b0;
    c_bit     = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_alu();
    test_ld_st_wait();
    test_branch();
    test_illegal_halt();
    test_reset_mid_mem();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
